// File: rtl/seg7_scan_driver_if.sv
// Digit-load and display-drive bundle for seg7_scan_driver.
// The master side loads BCD digits; the slave side (the driver) produces segment/anode drive.
interface seg7_scan_driver_if;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       load;
    logic [6:0] seg;
    logic [2:0] an;
    logic [1:0] scan_state;

    // load is a plain strobe with no back-pressure: the digits are sampled on every clk edge where load=1.
    modport master (output hundreds, output tens, output ones, output load,
                    input seg, input an, input scan_state);
    modport slave  (input hundreds, input tens, input ones, input load,
                    output seg, output an, output scan_state);
endinterface

// File: rtl/seg7_scan_driver.sv
// Three-digit multiplexed 7-segment scan driver with shadow digit registers and registered outputs.
// Optional leading-zero blanking is enabled with the macro LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int CLK_DIV    = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    seg7_scan_driver_if.slave bus
);
    localparam int              CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(CLK_DIV - 1);
    localparam logic [1:0]      ST_ONES  = 2'd0;
    localparam logic [1:0]      ST_TENS  = 2'd1;
    localparam logic [1:0]      ST_HUND  = 2'd2;
    localparam logic [6:0]      SEG_OFF  = {7{ACTIVE_LOW}};
    localparam logic [2:0]      AN_OFF   = {3{ACTIVE_LOW}};

    logic [CW-1:0] r_cnt;
    logic          w_tick;
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [3:0]    r_shd_h;
    logic [3:0]    r_shd_t;
    logic [3:0]    r_shd_o;
    logic [3:0]    w_digit;
    logic [2:0]    w_an_h;
    logic          w_blank;
    logic [6:0]    w_seg_h;
    logic [6:0]    r_seg;
    logic [2:0]    r_an;

    assign w_tick = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shd_h <= 4'd0;
            r_shd_t <= 4'd0;
            r_shd_o <= 4'd0;
        end else if (bus.load) begin
            r_shd_h <= bus.hundreds;
            r_shd_t <= bus.tens;
            r_shd_o <= bus.ones;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ONES: if (w_tick) w_state_nxt = ST_TENS;
            ST_TENS: if (w_tick) w_state_nxt = ST_HUND;
            ST_HUND: if (w_tick) w_state_nxt = ST_ONES;
            default: w_state_nxt = ST_ONES;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_ONES;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot selection; the unused state encoding drives nothing for its single cycle.
    always_comb begin
        w_digit = r_shd_o;
        w_an_h  = 3'b001;
        w_blank = 1'b0;
        case (r_state)
            ST_ONES: begin
                w_digit = r_shd_o;
                w_an_h  = 3'b001;
            end
            ST_TENS: begin
                w_digit = r_shd_t;
                w_an_h  = 3'b010;
`ifdef LEADING_ZERO_BLANK_EN
                w_blank = (r_shd_h == 4'd0) && (r_shd_t == 4'd0);
`else
                w_blank = 1'b0;
`endif
            end
            ST_HUND: begin
                w_digit = r_shd_h;
                w_an_h  = 3'b100;
`ifdef LEADING_ZERO_BLANK_EN
                w_blank = (r_shd_h == 4'd0);
`else
                w_blank = 1'b0;
`endif
            end
            default: begin
                w_digit = 4'd0;
                w_an_h  = 3'b000;
                w_blank = 1'b1;
            end
        endcase
    end

    // Active-high segment patterns {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    always_comb begin
        w_seg_h = 7'h40;
        case (w_digit)
            4'd0:    w_seg_h = 7'h3F;
            4'd1:    w_seg_h = 7'h06;
            4'd2:    w_seg_h = 7'h5B;
            4'd3:    w_seg_h = 7'h4F;
            4'd4:    w_seg_h = 7'h66;
            4'd5:    w_seg_h = 7'h6D;
            4'd6:    w_seg_h = 7'h7D;
            4'd7:    w_seg_h = 7'h07;
            4'd8:    w_seg_h = 7'h7F;
            4'd9:    w_seg_h = 7'h6F;
            default: w_seg_h = 7'h40;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else if (w_blank) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= w_seg_h ^ {7{ACTIVE_LOW}};
            r_an  <= w_an_h ^ {3{ACTIVE_LOW}};
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.scan_state = r_state;
endmodule
